// File: rtl/serial_mag_compare.sv
// serial_mag_compare: bit-serial MSB-first magnitude comparator.
// Operands are accepted over a valid/ready handshake. One bit pair per cycle
// goes to an external 1-bit compare cell. The first differing bit ends the
// operation early, and the verdict plus bits-examined count is returned over
// a second valid/ready handshake.
// Optional build macro: SERIAL_CMP_SIGNED_EN (two's complement operands).
module serial_mag_compare #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             bit_a,
    output logic             bit_b,
    output logic             bit_en,
    input  logic             cmp_lt,
    input  logic             cmp_gt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             res_lt,
    output logic             res_gt,
    output logic             res_eq,
    output logic [CNT_W-1:0] res_bits
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sh_a_q, sh_a_d, sh_b_q, sh_b_d;
    logic [CNT_W-1:0]   idx_q, idx_d, cnt_q, cnt_d;
    logic               res_lt_q, res_lt_d, res_gt_q, res_gt_d, res_eq_q, res_eq_d;
    logic [CNT_W-1:0]   res_bits_q, res_bits_d;
    logic               lt_eff, gt_eff;

    // Every output is decoded from registered state, so there is no path
    // from in_* to the compare cell.
    assign in_ready  = (state_q == IDLE);
    assign bit_en    = (state_q == SHIFT);
    assign out_valid = (state_q == DONE);
    assign bit_a     = bit_en & sh_a_q[WIDTH-1];
    assign bit_b     = bit_en & sh_b_q[WIDTH-1];
    assign res_lt    = res_lt_q;
    assign res_gt    = res_gt_q;
    assign res_eq    = res_eq_q;
    assign res_bits  = res_bits_q;

`ifdef SERIAL_CMP_SIGNED_EN
    // For the sign bit, a 1 means the value is smaller, so the cell flags are
    // swapped on the first step only.
    assign lt_eff = (cnt_q == '0) ? cmp_gt : cmp_lt;
    assign gt_eff = (cnt_q == '0) ? cmp_lt : cmp_gt;
`else
    assign lt_eff = cmp_lt;
    assign gt_eff = cmp_gt;
`endif

    // Next-state and datapath: load in IDLE, walk bits in SHIFT, hold in DONE
    always_comb begin
        state_d    = state_q;
        sh_a_d     = sh_a_q;
        sh_b_d     = sh_b_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        res_lt_d   = res_lt_q;
        res_gt_d   = res_gt_q;
        res_eq_d   = res_eq_q;
        res_bits_d = res_bits_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sh_a_d     = in_a;
                    sh_b_d     = in_b;
                    idx_d      = CNT_W'(WIDTH - 1);
                    cnt_d      = '0;
                    res_lt_d   = 1'b0;
                    res_gt_d   = 1'b0;
                    res_eq_d   = 1'b0;
                    res_bits_d = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Per-bit equality is only ever inferred from neither flag
                // being set. Lt has priority if the cell raises both flags.
                if (lt_eff) begin
                    res_lt_d   = 1'b1;
                    res_bits_d = cnt_q + CNT_W'(1);
                    state_d    = DONE;
                end else if (gt_eff) begin
                    res_gt_d   = 1'b1;
                    res_bits_d = cnt_q + CNT_W'(1);
                    state_d    = DONE;
                end else if (idx_q == '0) begin
                    res_eq_d   = 1'b1;
                    res_bits_d = cnt_q + CNT_W'(1);
                    state_d    = DONE;
                end else begin
                    sh_a_d = {sh_a_q[WIDTH-2:0], 1'b0};
                    sh_b_d = {sh_b_q[WIDTH-2:0], 1'b0};
                    idx_d  = idx_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers. Reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sh_a_q     <= '0;
            sh_b_q     <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            res_lt_q   <= 1'b0;
            res_gt_q   <= 1'b0;
            res_eq_q   <= 1'b0;
            res_bits_q <= '0;
        end else begin
            state_q    <= state_d;
            sh_a_q     <= sh_a_d;
            sh_b_q     <= sh_b_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            res_lt_q   <= res_lt_d;
            res_gt_q   <= res_gt_d;
            res_eq_q   <= res_eq_d;
            res_bits_q <= res_bits_d;
        end
    end

    // The compare cell must never claim both lt and gt for one bit pair.
    a_cell_flags_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(bit_en && cmp_lt && cmp_gt));

endmodule
